// File: rtl/lut_table_writer.sv
// lut_table_writer
//   Run-time loadable truth table for one reconfigurable LUT neuron slot.
//   A config stream writes the table beat by beat into a distributed-RAM
//   table. Once loaded, the table serves registered lookups with a latency of
//   one cycle.
//
//   Handshakes: a config beat transfers on a rising edge where
//   cfg_valid & cfg_ready are both 1. cfg_ready depends only on registered
//   state, never on cfg_valid. The lookup side has no backpressure: each
//   in_valid sampled while tbl_valid=1 produces exactly one out_valid pulse
//   on the next cycle.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_start              pulse: abandon current table, begin a new load
//   cfg_valid/ready/data   config beat stream (WORD bits per beat)
//   cfg_last               final beat marker; must coincide with beat BEATS-1
//   cfg_err                sticky framing error of last load, cleared by cfg_start
//   tbl_valid              table fully loaded, lookups are served
//   in_valid, in_data      lookup request and address
//   out_valid, out_data    lookup result, one cycle after the request
module lut_table_writer #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD-1:0]     cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                tbl_valid,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int TBITS = (2 ** IN_BITS) * OUT_BITS;
  localparam int BEATS = TBITS / WORD;
  localparam int PTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (TBITS > 1) ? $clog2(TBITS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Exposed as a plain internal signal so checkers can bind to it.
  state_t           state;
  logic [PTR_W-1:0] ptr;

  logic [WORD-1:0]  mem [BEATS];
  logic [TBITS-1:0] flat;
  logic [AW-1:0]    rd_base;
  logic             beat_write;

  // cfg_start takes priority: a beat presented in the same cycle is dropped.
  assign beat_write = (state == S_LOAD) && cfg_valid && !cfg_start;

  // Beat b bit k lands at table bit b*WORD+k.
  always_comb begin
    flat = '0;
    for (int b = 0; b < BEATS; b++) begin
      flat[b*WORD +: WORD] = mem[b];
    end
  end

  assign rd_base = AW'(in_data) * AW'(OUT_BITS);

  // Table storage is deliberately not reset: partial loads stay in RAM.
  always_ff @(posedge clk) begin
    if (beat_write) begin
      mem[ptr] <= cfg_data;
    end
  end

  // Load-control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      ptr       <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      tbl_valid <= 1'b0;
    end else if (cfg_start) begin
      state     <= S_LOAD;
      ptr       <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      tbl_valid <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          cfg_ready <= 1'b0;
        end
        S_LOAD: begin
          if (cfg_valid) begin
            if (ptr == LAST_PTR) begin
              ptr       <= '0;
              cfg_ready <= 1'b0;
              if (cfg_last) begin
                state     <= S_READY;
                tbl_valid <= 1'b1;
              end else begin
                state   <= S_EMPTY;
                cfg_err <= 1'b1;
              end
            end else if (cfg_last) begin
              // Early last: the table is short, reject it.
              state     <= S_EMPTY;
              ptr       <= '0;
              cfg_ready <= 1'b0;
              cfg_err   <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        S_READY: begin
          cfg_ready <= 1'b0;
        end
        default: begin
          state     <= S_EMPTY;
          ptr       <= '0;
          cfg_ready <= 1'b0;
          tbl_valid <= 1'b0;
        end
      endcase
    end
  end

  // Lookup path: tbl_valid is sampled pre-edge, so a lookup coinciding with
  // cfg_start is still served from the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && tbl_valid;
      if (in_valid && tbl_valid) begin
        out_data <= flat[rd_base +: OUT_BITS];
      end
    end
  end

endmodule
